shift_ser4: RTL

Parallel-in, serial-out transmitter. It is the sending end of the serial link whose receiver is a right-shifting serial-in shift register. It accepts a parallel word through a valid/ready handshake and buffers one word ahead. It drives the word out LSB-first, one bit per clock, so a WIDTH-bit right-shift receiver clocked in lockstep holds the original word after WIDTH shifts.

---
 rtl/shift_ser4.sv | 137 +++++++++++++
 1 files changed

// File: rtl/shift_ser4.sv
// Parallel-in, serial-out transmitter: one-word holding slot feeding an LSB-first
// shifter with optional forced idle gap between frames.
module shift_ser4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] Par_in,
  input  logic             Load_valid,
  output logic             Load_ready,
  output logic             Data_out,
  output logic             Frame_valid,
  output logic             Frame_last
);

  localparam int unsigned BCW = $clog2(WIDTH);
  localparam int unsigned GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_sreg;
  logic [BCW-1:0]   r_bcnt;
  logic [GCW-1:0]   r_gcnt;
  logic             r_data_out;
  logic             r_frame_valid;
  logic             r_frame_last;

  state_t           w_state;
  logic [WIDTH-1:0] w_hold;
  logic             w_hold_full;
  logic [WIDTH-1:0] w_sreg;
  logic [BCW-1:0]   w_bcnt;
  logic [GCW-1:0]   w_gcnt;
  logic             w_take;
  logic             w_data_out;
  logic             w_frame_valid;
  logic             w_frame_last;

  // Next-state, hold-slot and output logic; outputs derive from next-state values
  always_comb begin
    w_state     = r_state;
    w_hold      = r_hold;
    w_hold_full = r_hold_full;
    w_sreg      = r_sreg;
    w_bcnt      = r_bcnt;
    w_gcnt      = r_gcnt;
    w_take      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_take = r_hold_full;
      end
      ST_SHIFT: begin
        w_sreg = r_sreg >> 1;
        w_bcnt = r_bcnt + BCW'(1);
        if (r_bcnt == LAST_BIT) begin
          if (GAP > 0) begin
            w_state = ST_GAP;
            w_gcnt  = GCW'(GAP - 1);
          end else if (r_hold_full) begin
            w_take = 1'b1;
          end else begin
            w_state = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (r_gcnt == '0) begin
          if (r_hold_full) begin
            w_take = 1'b1;
          end else begin
            w_state = ST_IDLE;
          end
        end else begin
          w_gcnt = r_gcnt - GCW'(1);
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // Transfer and accept are mutually exclusive: accept needs an empty slot
    if (w_take) begin
      w_state     = ST_SHIFT;
      w_sreg      = r_hold;
      w_bcnt      = '0;
      w_hold_full = 1'b0;
    end else if (Load_valid && !r_hold_full) begin
      w_hold      = Par_in;
      w_hold_full = 1'b1;
    end

    w_frame_valid = (w_state == ST_SHIFT);
    w_data_out    = w_frame_valid & w_sreg[0];
    w_frame_last  = w_frame_valid && (w_bcnt == LAST_BIT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_sreg        <= '0;
      r_bcnt        <= '0;
      r_gcnt        <= '0;
      r_data_out    <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_last  <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_hold        <= w_hold;
      r_hold_full   <= w_hold_full;
      r_sreg        <= w_sreg;
      r_bcnt        <= w_bcnt;
      r_gcnt        <= w_gcnt;
      r_data_out    <= w_data_out;
      r_frame_valid <= w_frame_valid;
      r_frame_last  <= w_frame_last;
    end
  end

  assign Load_ready  = ~r_hold_full;
  assign Data_out    = r_data_out;
  assign Frame_valid = r_frame_valid;
  assign Frame_last  = r_frame_last;

endmodule
